prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
Boot-time program loader that sits directly upstream of the pipelined core's 128x16 unified memory. It receives a byte stream (length header, big-endian 16-bit words, XOR checksum) and writes the words into memory starting at the core's reset PC. It holds the core stalled until a verified image is resident, then raises core_run. A bad length or a bad checksum leaves the core held and flags an error.

Parameters:
ADDR_W, 7, memory address width
DATA_W, 16, memory word width
MEM_DEPTH, 128, number of memory words
START_ADDR, 8, first address written; equals the core's reset PC

Ports:
CLOCK_50  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
rx_data  input  8  incoming byte
rx_valid  input  1  rx_data valid this cycle
rx_ready  output  1  loader accepts a byte; transfer occurs when rx_valid && rx_ready
load_req  input  1  restart a load; honoured only in DONE or ERR
mem_we  output  1  one-cycle memory write strobe
mem_addr  output  ADDR_W  write address
mem_wdata  output  DATA_W  write data
core_run  output  1  core may fetch/execute; low = core held stalled
busy  output  1  load in progress
err  output  1  sticky error; cleared by reset or an accepted load_req

Behaviour:
- Stream format, in order:
  - LEN_HI, LEN_LO: 16-bit word count N.
  - N words, each as HI byte then LO byte.
  - CHK byte: XOR of every preceding byte, including the length bytes.
- States: LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERR.
- Reset values:
  - state = LEN_HI; word index = 0; checksum accumulator = 0; hi-byte holding register = 0.
  - mem_we = 0, mem_addr = 0, mem_wdata = 0, core_run = 0, err = 0, busy = 1.
- rx_ready = 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK; 0 in DONE and ERR. rx_ready is combinational from state. The loader never back-pressures mid-image.
- Every accepted byte XORs into the accumulator.
- LEN_HI -> LEN_LO on an accepted byte.
- LEN_LO, on an accepted byte:
  - N > MEM_DEPTH - START_ADDR (120): -> ERR.
  - N == 0: -> CHECK.
  - otherwise: -> DATA_HI.
- DATA_HI -> DATA_LO on an accepted byte; the byte is held.
- DATA_LO, on an accepted byte:
  - Next cycle: mem_we = 1, mem_addr = START_ADDR + index, mem_wdata = {held, byte}.
  - index increments.
  - Goes to CHECK after the N-th word, else back to DATA_HI.
- Write latency is 1 cycle after the LO handshake. Back-to-back bytes (rx_valid held high) sustain one write every 2 cycles.
- mem_we is high for exactly one cycle per word; mem_addr and mem_wdata hold their value otherwise.
- CHECK, on an accepted byte:
  - accumulator XOR byte == 0: -> DONE.
  - otherwise: -> ERR.
- Outputs are registered from next-state:
  - core_run = (state == DONE); rises the cycle after the CHK handshake.
  - err = (state == ERR).
  - busy = !(DONE || ERR).
- DONE and ERR are terminal until load_req. An accepted load_req:
  - next cycle: state = LEN_HI; accumulator and index cleared; core_run = 0; err = 0.
  - Memory contents are not erased.
- load_req in any other state is ignored.
- rx_valid in DONE or ERR is ignored (no handshake).
- Reset mid-load: abort immediately. Words already written stay in memory. The last mem_we write still completes if it was issued in the reset cycle. The loader returns to LEN_HI with core_run = 0.
- Reset and load_req in the same cycle: reset wins.
- Address arithmetic: index width is ADDR_W. START_ADDR + index never exceeds MEM_DEPTH - 1, guaranteed by the LEN_LO check.

Decomposition:
- Shared package holds:
  - the state enum;
  - START_ADDR, MEM_DEPTH, ADDR_W, DATA_W constants shared with the core (reset PC = START_ADDR).
- No sub-module needed: FSM, index counter and XOR accumulator fit in one module.

Test Plan:
- Basic load: reset, then bytes 00 02 12 61 12 62 01 with rx_valid held high.
  - Required: writes (8, 0x1261) and (9, 0x1262).
  - core_run = 1 one cycle after the 01 handshake; err = 0.
- Bad checksum: same stream with CHK = 00.
  - Required: both writes occur; state ERR; err = 1; core_run stays 0; rx_ready = 0.
- Oversize length: bytes 00 79 (N = 121).
  - Required: ERR immediately after LEN_LO; no mem_we; err = 1.
- Empty image: bytes 00 00 00.
  - Required: no writes; core_run = 1.
  - Then assert load_req: core_run = 0, err = 0, rx_ready = 1 next cycle.
- Gapped stream: the basic stream with rx_valid low for 3 cycles between bytes.
  - Required: identical writes and result; no spurious mem_we.
- Reset mid-load: reset after byte 0x12 of word 1.
  - Required: state LEN_HI, core_run = 0, no further writes.
  - A full reload afterwards succeeds.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Constants shared between the boot loader and the pipelined core, plus the
// loader's state encoding.
package prog_loader_pkg;

    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 16;
    localparam int MEM_DEPTH  = 128;
    localparam int START_ADDR = 8;   // core reset PC
    localparam int MAX_WORDS  = MEM_DEPTH - START_ADDR;

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/prog_loader.sv
// Boot-time loader: parses a length-prefixed, XOR-checksummed byte stream into
// the core's memory at the reset PC and releases the core once it verifies.
module prog_loader
    import prog_loader_pkg::*;
(
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              load_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              core_run,
    output logic              busy,
    output logic              err
);

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] len;
    logic [7:0]        acc;
    logic [7:0]        hold;

    logic              accept;
    logic [15:0]       len_word;
    logic [ADDR_W-1:0] idx_next;

    assign rx_ready = (state != S_DONE) && (state != S_ERR);
    assign accept   = rx_valid && rx_ready;
    assign len_word = {hold, rx_data};
    assign idx_next = idx + ADDR_W'(1);

    // Status outputs are set alongside each state change so they track the
    // registered state without an extra decode stage.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state     <= S_LEN_HI;
            idx       <= '0;
            len       <= '0;
            acc       <= '0;
            hold      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            core_run  <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b1;
        end else begin
            mem_we <= 1'b0;
            if (accept) begin
                acc <= acc ^ rx_data;
            end
            case (state)
                S_LEN_HI: begin
                    if (accept) begin
                        hold  <= rx_data;
                        state <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (accept) begin
                        len <= len_word[ADDR_W-1:0];
                        if (len_word > 16'(MAX_WORDS)) begin
                            state <= S_ERR;
                            err   <= 1'b1;
                            busy  <= 1'b0;
                        end else if (len_word == '0) begin
                            state <= S_CHECK;
                        end else begin
                            state <= S_DATA_HI;
                        end
                    end
                end
                S_DATA_HI: begin
                    if (accept) begin
                        hold  <= rx_data;
                        state <= S_DATA_LO;
                    end
                end
                S_DATA_LO: begin
                    if (accept) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= ADDR_W'(START_ADDR) + idx;
                        mem_wdata <= {hold, rx_data};
                        idx       <= idx_next;
                        state     <= (idx_next == len) ? S_CHECK : S_DATA_HI;
                    end
                end
                S_CHECK: begin
                    if (accept) begin
                        busy <= 1'b0;
                        if ((acc ^ rx_data) == '0) begin
                            state    <= S_DONE;
                            core_run <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    if (load_req) begin
                        state    <= S_LEN_HI;
                        acc      <= '0;
                        idx      <= '0;
                        core_run <= 1'b0;
                        err      <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                default: state <= S_LEN_HI;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a stream-level model predicts outputs
// from the bytes accepted so far; directed and random images exercise it.
module tb_prog_loader;

    logic        CLOCK_50 = 1'b0;
    logic        reset    = 1'b1;
    logic [7:0]  rx_data  = '0;
    logic        rx_valid = 1'b0;
    logic        load_req = 1'b0;
    logic        rx_ready;
    logic        mem_we;
    logic [6:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        core_run;
    logic        busy;
    logic        err;

    prog_loader dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .load_req (load_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .core_run (core_run),
        .busy     (busy),
        .err      (err)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic        checking = 1'b0;

    // Model: the bytes accepted in the current load, plus the expected write port.
    logic [7:0]  q[$];
    logic        exp_we    = 1'b0;
    logic [6:0]  exp_addr  = '0;
    logic [15:0] exp_wdata = '0;
    logic [22:0] wlog[$];

    // 0 = still loading, 1 = verified image, 2 = error
    function automatic int mstat();
        int unsigned n;
        logic [7:0]  x;
        if (q.size() < 2) return 0;
        n = {q[0], q[1]};
        if (n > 120) return 2;
        if (q.size() < 2 * n + 3) return 0;
        x = '0;
        for (int unsigned i = 0; i < 2 * n + 3; i++) x ^= q[i];
        return (x == 8'h00) ? 1 : 2;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_update(input logic v, input logic [7:0] d, input logic lr, input logic rst);
        int st;
        int unsigned p, n, k;
        st     = mstat();
        exp_we = 1'b0;
        if (rst) begin
            q.delete();
            exp_addr  = '0;
            exp_wdata = '0;
        end else if (st == 0 && v) begin
            p = q.size();
            if (p >= 3 && ((p - 3) % 2) == 0) begin
                n = {q[0], q[1]};
                k = (p - 3) / 2;
                if (k < n) begin
                    exp_we    = 1'b1;
                    exp_addr  = 7'(8 + k);
                    exp_wdata = {q[p-1], d};
                end
            end
            q.push_back(d);
        end else if (st != 0 && lr) begin
            q.delete();
        end
    endtask

    always @(negedge CLOCK_50) begin
        if (checking) begin
            int st;
            st = mstat();
            check("rx_ready",  32'(rx_ready),  32'(st == 0));
            check("core_run",  32'(core_run),  32'(st == 1));
            check("err",       32'(err),       32'(st == 2));
            check("busy",      32'(busy),      32'(st == 0));
            check("mem_we",    32'(mem_we),    32'(exp_we));
            check("mem_addr",  32'(mem_addr),  32'(exp_addr));
            check("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
            if (mem_we) wlog.push_back({mem_addr, mem_wdata});
        end
    end

    task automatic step(input logic v, input logic [7:0] d, input logic lr, input logic rst);
        rx_valid = v;
        rx_data  = d;
        load_req = lr;
        reset    = rst;
        @(posedge CLOCK_50);
        #1;
        model_update(v, d, lr, rst);
        @(negedge CLOCK_50);
    endtask

    task automatic send(input logic [7:0] b, input int unsigned gap);
        repeat (gap) step(1'b0, 8'($urandom), 1'b0, 1'b0);
        step(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 8'h00, 1'b0, 1'b1);
        wlog.delete();
    endtask

    logic [7:0] basic[7] = '{8'h00, 8'h02, 8'h12, 8'h61, 8'h12, 8'h62, 8'h01};

    initial begin
        @(negedge CLOCK_50);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        checking = 1'b1;
        do_reset();

        // Basic load, back-to-back bytes
        for (int i = 0; i < 6; i++) send(basic[i], 0);
        check("basic_pre_run", 32'(core_run), 32'h0);
        send(basic[6], 0);
        check("basic_run", 32'(core_run), 32'h1);
        check("basic_err", 32'(err), 32'h0);
        check("basic_nw", wlog.size(), 2);
        if (wlog.size() == 2) begin
            check("basic_w0", 32'(wlog[0]), 32'({7'd8, 16'h1261}));
            check("basic_w1", 32'(wlog[1]), 32'({7'd9, 16'h1262}));
        end

        // Bad checksum
        do_reset();
        for (int i = 0; i < 6; i++) send(basic[i], 0);
        send(8'h00, 0);
        check("badchk_nw", wlog.size(), 2);
        check("badchk_err", 32'(err), 32'h1);
        check("badchk_run", 32'(core_run), 32'h0);
        check("badchk_rdy", 32'(rx_ready), 32'h0);
        send(8'h55, 0);
        check("badchk_stuck", 32'(err), 32'h1);

        // Oversize length
        do_reset();
        send(8'h00, 0);
        send(8'h79, 0);
        check("over_err", 32'(err), 32'h1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("over_nw", wlog.size(), 0);

        // Boundary length 120 is accepted
        do_reset();
        send(8'h00, 0);
        send(8'h78, 0);
        check("max_len_ok", 32'(rx_ready), 32'h1);
        check("max_len_err", 32'(err), 32'h0);

        // Empty image, then reload request
        do_reset();
        send(8'h00, 0);
        send(8'h00, 0);
        send(8'h00, 0);
        check("empty_run", 32'(core_run), 32'h1);
        check("empty_nw", wlog.size(), 0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("reload_run", 32'(core_run), 32'h0);
        check("reload_err", 32'(err), 32'h0);
        check("reload_rdy", 32'(rx_ready), 32'h1);

        // Gapped stream
        do_reset();
        for (int i = 0; i < 7; i++) send(basic[i], 3);
        check("gap_run", 32'(core_run), 32'h1);
        check("gap_nw", wlog.size(), 2);
        if (wlog.size() == 2) begin
            check("gap_w0", 32'(wlog[0]), 32'({7'd8, 16'h1261}));
            check("gap_w1", 32'(wlog[1]), 32'({7'd9, 16'h1262}));
        end

        // Reset mid-load, then full reload
        do_reset();
        for (int i = 0; i < 3; i++) send(basic[i], 0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("midrst_run", 32'(core_run), 32'h0);
        check("midrst_rdy", 32'(rx_ready), 32'h1);
        check("midrst_nw", wlog.size(), 0);
        for (int i = 0; i < 7; i++) send(basic[i], 0);
        check("midrst_reload", 32'(core_run), 32'h1);

        // Reset and load_req together: reset wins
        step(1'b0, 8'h00, 1'b1, 1'b1);
        check("rst_wins", 32'(busy), 32'h1);

        // Randomized images against the model
        for (int t = 0; t < 60; t++) begin
            int unsigned mode, nw, rstpos, pos;
            logic [7:0]  img[$];
            logic [7:0]  x;
            logic [15:0] len;
            if (mstat() != 0) begin
                repeat ($urandom_range(0, 2)) step(1'b1, 8'($urandom), 1'b0, 1'b0);
                step($urandom_range(0, 1) == 1, 8'($urandom), 1'b1, 1'b0);
            end
            mode = $urandom_range(0, 9);
            nw   = $urandom_range(0, 6);
            len  = (mode == 0) ? 16'($urandom_range(121, 400)) : 16'(nw);
            img.delete();
            img.push_back(len[15:8]);
            img.push_back(len[7:0]);
            if (mode != 0) begin
                for (int unsigned i = 0; i < 2 * nw; i++) img.push_back(8'($urandom));
                x = '0;
                foreach (img[i]) x ^= img[i];
                if (mode == 1) x ^= 8'($urandom_range(1, 255));
                img.push_back(x);
            end
            rstpos = (mode == 2) ? $urandom_range(0, img.size() - 1) : img.size() + 1;
            pos = 0;
            foreach (img[i]) begin
                if (pos == rstpos) begin
                    step(1'b0, 8'h00, 1'($urandom_range(0, 1)), 1'b1);
                    break;
                end
                repeat ($urandom_range(0, 2)) step(1'b0, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
                step(1'b1, img[i], 1'($urandom_range(0, 1)), 1'b0);
                pos++;
            end
        end
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
